// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// instruction size and PC alignment constants.
package fetch_pkg;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_WAIT  = 2'd1,
        FS_FAULT = 2'd2
    } fetch_state_e;

    localparam int INSTR_BYTES = 4;

    // Low address bits that must be zero in any fetch address.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // MAX_WAIT may be as large as 255, so eight bits hold any wait count.
    localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts WAIT cycles without an ack. expired_o is high on the cycle whose
// missing ack would bring the count to MAX_WAIT.
module fetch_timeout_counter
    import fetch_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(MAX_WAIT - 1);

    logic [WAIT_CNT_W-1:0] wait_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            wait_cnt_q <= '0;
        end else if (enable_i) begin
            wait_cnt_q <= wait_cnt_q + WAIT_CNT_W'(1);
        end
    end

    assign expired_o = enable_i && (wait_cnt_q == LAST_CNT);

endmodule

// File: rtl/instr_fetch_unit.sv
// Front-end fetch stage: owns the PC, issues one memory read at a time over
// req/ack, feeds the instruction register and handles redirects and timeouts.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       instr_out,
    output logic              load_en,
    output logic [ADDR_W-1:0] pc_out,
    output logic              fetch_busy,
    output logic              fetch_fault
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              redirect_pending_q;
    logic [ADDR_W-1:0] redirect_target_q;

    logic [ADDR_W-1:0] redirect_aligned;
    logic              timeout_clear;
    logic              timeout_enable;
    logic              timeout_expired;

    assign redirect_aligned = redirect_pc & ~ADDR_W'(ALIGN_MASK);
    assign timeout_clear    = (state_q != FS_WAIT);
    assign timeout_enable   = (state_q == FS_WAIT) && !mem_ack;

    fetch_timeout_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (timeout_clear),
        .enable_i  (timeout_enable),
        .expired_o (timeout_expired)
    );

    // NOTE: reset is synchronous and every state update is non-blocking, so all
    // outputs change together on the edge; load_en defaults low to form a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= FS_IDLE;
            pc_q               <= RESET_PC;
            redirect_pending_q <= 1'b0;
            redirect_target_q  <= '0;
            mem_req            <= 1'b0;
            mem_addr           <= RESET_PC;
            instr_out          <= '0;
            pc_out             <= '0;
            load_en            <= 1'b0;
            fetch_busy         <= 1'b0;
            fetch_fault        <= 1'b0;
        end else begin
            load_en <= 1'b0;
            case (state_q)
                FS_IDLE: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_aligned;
                    end else if (fetch_en) begin
                        mem_req    <= 1'b1;
                        mem_addr   <= pc_q;
                        fetch_busy <= 1'b1;
                        state_q    <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (mem_ack) begin
                        mem_req            <= 1'b0;
                        fetch_busy         <= 1'b0;
                        redirect_pending_q <= 1'b0;
                        state_q            <= FS_IDLE;
                        // A redirect seen during the request makes its data stale.
                        if (redirect_valid) begin
                            pc_q <= redirect_aligned;
                        end else if (redirect_pending_q) begin
                            pc_q <= redirect_target_q;
                        end else begin
                            instr_out <= mem_rdata;
                            pc_out    <= mem_addr;
                            load_en   <= 1'b1;
                            pc_q      <= pc_q + ADDR_W'(INSTR_BYTES);
                        end
                    end else begin
                        if (redirect_valid) begin
                            redirect_pending_q <= 1'b1;
                            redirect_target_q  <= redirect_aligned;
                        end
                        if (timeout_expired) begin
                            mem_req     <= 1'b0;
                            fetch_busy  <= 1'b0;
                            fetch_fault <= 1'b1;
                            state_q     <= FS_FAULT;
                        end
                    end
                end
                FS_FAULT: begin
                end
                default: begin
                    mem_req    <= 1'b0;
                    fetch_busy <= 1'b0;
                    state_q    <= FS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// fetches, checked against a transaction-level model of the PC and IR outputs.
module tb_instr_fetch_unit;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;
    localparam int          MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr_out;
    logic        load_en;
    logic [31:0] pc_out;
    logic        fetch_busy;
    logic        fetch_fault;

    int n_checks = 0;
    int n_errors = 0;

    // Model: address of the next fetch and the last value loaded into the IR.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc_out;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr_out      (instr_out),
        .load_en        (load_en),
        .pc_out         (pc_out),
        .fetch_busy     (fetch_busy),
        .fetch_fault    (fetch_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc     = RESET_PC;
        m_instr  = '0;
        m_pc_out = '0;
    endtask

    // One complete fetch from IDLE. Wait cycle i (0..delay) drives a redirect if
    // redir_mask[i] is set; the ack arrives on wait cycle 'delay'.
    task automatic do_fetch(input int delay, input logic [31:0] redir_mask,
                            input bit rand_pc, input logic [31:0] fixed_pc,
                            input logic [31:0] data);
        logic [31:0] addr;
        logic [31:0] target;
        bit          redirected;
        addr       = m_pc;
        target     = '0;
        redirected = 1'b0;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        mem_ack        = 1'b0;
        step();
        check("req_rise", mem_req, 1);
        check("req_addr", mem_addr, addr);
        check("busy_set", fetch_busy, 1);
        for (int i = 0; i <= delay; i++) begin
            mem_ack        = (i == delay);
            mem_rdata      = (i == delay) ? data : $urandom;
            fetch_en       = 1'($urandom_range(0, 1));
            redirect_valid = redir_mask[i];
            redirect_pc    = rand_pc ? $urandom : fixed_pc;
            if (redirect_valid) begin
                redirected = 1'b1;
                target     = redirect_pc & ~32'h3;
            end
            step();
            if (i < delay) begin
                check("hold_req", mem_req, 1);
                check("hold_addr", mem_addr, addr);
                check("hold_busy", fetch_busy, 1);
                check("no_load_in_wait", load_en, 0);
            end
        end
        check("req_drop", mem_req, 0);
        check("busy_drop", fetch_busy, 0);
        if (redirected) begin
            m_pc = target;
            check("discard_no_load", load_en, 0);
        end else begin
            m_pc     = addr + 32'd4;
            m_instr  = data;
            m_pc_out = addr;
            check("load_pulse", load_en, 1);
        end
        check("instr_out", instr_out, m_instr);
        check("pc_out", pc_out, m_pc_out);
        check("no_fault", fetch_fault, 0);
        mem_ack        = 1'b0;
        redirect_valid = 1'b0;
        fetch_en       = 1'b0;
        step();
        check("load_single_cycle", load_en, 0);
        check("idle_no_req", mem_req, 0);
    endtask

    task automatic idle_redirect(input logic [31:0] pc);
        fetch_en       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        mem_ack        = 1'b0;
        step();
        check("idle_redir_no_req", mem_req, 0);
        m_pc           = pc & ~32'h3;
        redirect_valid = 1'b0;
        fetch_en       = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_ack        = 1'b0;
        mem_rdata      = '0;
        step();
        step();
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, RESET_PC);
        check("rst_instr", instr_out, 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_load", load_en, 0);
        check("rst_busy", fetch_busy, 0);
        check("rst_fault", fetch_fault, 0);
        reset    = 1'b0;
        fetch_en = 1'b0;
        model_reset();

        // Wrap from the top of memory, then the test-plan word at address 0.
        do_fetch(0, 32'h0, 1'b0, 32'h0, 32'h1234_5678);
        do_fetch(0, 32'h0, 1'b0, 32'h0, 32'h0050_0093);
        do_fetch(1, 32'h0, 1'b0, 32'h0, 32'h0000_0013);
        do_fetch(5, 32'h0, 1'b0, 32'h0, 32'h00A0_0113);

        // Redirect early in WAIT at 0xC, then in the ack cycle.
        do_fetch(3, 32'h1, 1'b0, 32'h100, 32'hBAD0_0001);
        do_fetch(0, 32'h0, 1'b0, 32'h0, 32'h0000_0113);
        idle_redirect(32'h0000_000C);
        do_fetch(3, 32'h8, 1'b0, 32'h100, 32'hBAD0_0002);
        do_fetch(0, 32'h0, 1'b0, 32'h0, 32'h0000_0213);

        idle_redirect(32'h0000_0203);
        do_fetch(0, 32'h0, 1'b0, 32'h0, 32'h0000_0313);

        // Several redirects in one request, and the longest ack delay before timeout.
        do_fetch(4, 32'h0000_000B, 1'b1, 32'h0, 32'hBAD0_0003);
        do_fetch(MAX_WAIT - 1, 32'h0, 1'b0, 32'h0, 32'h0000_0413);

        for (int n = 0; n < 40; n++) begin
            int          d;
            logic [31:0] mask;
            d    = $urandom_range(0, MAX_WAIT - 1);
            mask = ($urandom_range(0, 2) == 0) ? ($urandom & $urandom) : 32'h0;
            do_fetch(d, mask, 1'b1, 32'h0, $urandom);
            if ($urandom_range(0, 3) == 0) idle_redirect($urandom);
            repeat ($urandom_range(0, 2)) begin
                step();
                check("gap_no_req", mem_req, 0);
            end
        end

        // Reset in the middle of WAIT, with an ack arriving on the reset edge.
        fetch_en = 1'b1;
        step();
        check("midwait_req", mem_req, 1);
        step();
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        check("midwait_rst_req", mem_req, 0);
        check("midwait_rst_load", load_en, 0);
        check("midwait_rst_busy", fetch_busy, 0);
        check("midwait_rst_addr", mem_addr, RESET_PC);
        reset    = 1'b0;
        mem_ack  = 1'b0;
        fetch_en = 1'b0;
        model_reset();
        step();
        check("midwait_no_late_load", load_en, 0);
        do_fetch(0, 32'h0, 1'b0, 32'h0, 32'h0000_0513);

        // Memory never acks: fault after MAX_WAIT wait cycles, then sticky.
        fetch_en = 1'b1;
        mem_ack  = 1'b0;
        step();
        check("to_req_rise", mem_req, 1);
        for (int i = 1; i <= MAX_WAIT; i++) begin
            fetch_en = 1'($urandom_range(0, 1));
            step();
            if (i < MAX_WAIT) check("to_hold_req", mem_req, 1);
        end
        check("to_req_drop", mem_req, 0);
        check("to_fault_set", fetch_fault, 1);
        check("to_busy_drop", fetch_busy, 0);
        repeat (5) begin
            fetch_en       = 1'b1;
            redirect_valid = 1'($urandom_range(0, 1));
            redirect_pc    = $urandom;
            step();
            check("fault_sticky", fetch_fault, 1);
            check("fault_no_req", mem_req, 0);
            check("fault_no_load", load_en, 0);
        end
        redirect_valid = 1'b0;
        fetch_en       = 1'b0;
        reset          = 1'b1;
        step();
        check("fault_rst_clear", fetch_fault, 0);
        check("fault_rst_addr", mem_addr, RESET_PC);
        reset = 1'b0;
        model_reset();
        do_fetch(0, 32'h0, 1'b0, 32'h0, 32'h0000_0613);
        do_fetch(2, 32'h0, 1'b0, 32'h0, 32'h0000_0713);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
